axi_stride_read_master: RTL and testbench

- Synthesizable AXI read-address/read-data master that sits directly upstream of prefetcherTop and drives its s_ar_* / s_r_* slave side.
- Issues a programmed sequence of strided read bursts with one transaction ID and a bounded number of outstanding requests.
- Consumes and checks returned data so benches can replay access patterns, such as GPGPU traces, at hardware rate instead of with task-based stimulus.

---
 rtl/axi_stride_read_master.sv | 197 +++++++++++++++++++
 tb/tb_axi_stride_read_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stride_read_master.sv
// axi_stride_read_master: issues num_reqs strided AXI read bursts (single ID,
// bounded outstanding count) and consumes/checks the returned R beats.
// Ports: clk/rst; start + config (base_addr, stride, num_reqs, burst_len,
//   trans_id, max_outstanding); AR master channel m_ar_*; R channel m_r_*;
//   status busy, done (1-cycle pulse), error[2:0] (sticky: ID mismatch,
//   early last, missing last), beats_rcvd.
// Optional: define STRIDE_MASTER_CHECKSUM_EN to add output checksum, the
//   running XOR of accepted m_r_data (cleared on start and on reset).
module axi_stride_read_master #(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_OUTSTANDING      = 3,
  parameter int REQ_CNT_WIDTH        = 16,
  localparam int DATA_WIDTH          = 8 << LOG_BLOCK_DATA_BYTES,
  localparam int OW                  = LOG_OUTSTANDING + 1,
  localparam int BW                  = REQ_CNT_WIDTH + BURST_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       base_addr,
  input  logic [ADDR_BITS-1:0]       stride,
  input  logic [REQ_CNT_WIDTH-1:0]   num_reqs,
  input  logic [BURST_LEN_WIDTH-1:0] burst_len,
  input  logic [TID_WIDTH-1:0]       trans_id,
  input  logic [OW-1:0]              max_outstanding,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       m_r_valid,
  output logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [DATA_WIDTH-1:0]      m_r_data,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 error,
`ifdef STRIDE_MASTER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]      checksum,
`endif
  output logic [BW-1:0]              beats_rcvd
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d, stride_q, stride_d;
  logic [REQ_CNT_WIDTH-1:0]   num_q, num_d, issued_q, issued_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d, beat_idx_q, beat_idx_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [OW-1:0]              limit_q, limit_d, outst_q, outst_d;
  logic [2:0]                 err_q, err_d;
  logic [BW-1:0]              beats_q, beats_d;
  logic                       zdone_q, zdone_d;
  logic                       ar_hs, r_acc, retire;
`ifdef STRIDE_MASTER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      csum_q, csum_d;
`else
  logic                       unused_data;
  assign unused_data = ^m_r_data;
`endif

  // Valid depends only on registered state, so there is no ready->valid path;
  // the limit is compared against the pre-retire outstanding count.
  assign m_ar_valid = (state_q == ISSUE) && (issued_q < num_q) && (outst_q < limit_q);
  assign m_ar_addr  = addr_q;
  assign m_ar_len   = len_q;
  assign m_ar_id    = id_q;
  assign m_r_ready  = (state_q == ISSUE) || (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) || zdone_q;
  assign error      = err_q;
  assign beats_rcvd = beats_q;
  assign ar_hs      = m_ar_valid && m_ar_ready;
  assign r_acc      = m_r_valid && m_r_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    num_d      = num_q;
    issued_d   = issued_q;
    len_d      = len_q;
    beat_idx_d = beat_idx_q;
    id_d       = id_q;
    limit_d    = limit_q;
    outst_d    = outst_q;
    err_d      = err_q;
    beats_d    = beats_q;
    zdone_d    = 1'b0;
    retire     = 1'b0;
`ifdef STRIDE_MASTER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    // R beat checking; only possible in ISSUE/DRAIN because ready gates it.
    if (r_acc) begin
      beats_d = beats_q + BW'(1);
`ifdef STRIDE_MASTER_CHECKSUM_EN
      csum_d  = csum_q ^ m_r_data;
`endif
      if (m_r_id != id_q) err_d[0] = 1'b1;
      if (m_r_last && (beat_idx_q < len_q)) err_d[1] = 1'b1;
      if (!m_r_last && (beat_idx_q == len_q)) err_d[2] = 1'b1;
      beat_idx_d = m_r_last ? '0 : beat_idx_q + BURST_LEN_WIDTH'(1);
      if (m_r_last) begin
        // A last with nothing outstanding is a slave violation: flag, clamp at 0.
        if (outst_q == '0) err_d[1] = 1'b1;
        else               retire   = 1'b1;
      end
    end

    if (ar_hs) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + REQ_CNT_WIDTH'(1);
    end
    if (ar_hs && !retire)      outst_d = outst_q + OW'(1);
    else if (!ar_hs && retire) outst_d = outst_q - OW'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef STRIDE_MASTER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (num_reqs != '0) begin
            addr_d     = base_addr;
            stride_d   = stride;
            num_d      = num_reqs;
            len_d      = burst_len;
            id_d       = trans_id;
            limit_d    = (max_outstanding == '0) ? OW'(1) : max_outstanding;
            issued_d   = '0;
            outst_d    = '0;
            beat_idx_d = '0;
            err_d      = '0;
            beats_d    = '0;
            state_d    = ISSUE;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      ISSUE:   if (issued_d == num_q) state_d = DRAIN;
      DRAIN:   if (outst_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      len_q      <= '0;
      beat_idx_q <= '0;
      id_q       <= '0;
      limit_q    <= '0;
      outst_q    <= '0;
      err_q      <= '0;
      beats_q    <= '0;
      zdone_q    <= 1'b0;
`ifdef STRIDE_MASTER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      len_q      <= len_d;
      beat_idx_q <= beat_idx_d;
      id_q       <= id_d;
      limit_q    <= limit_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
      zdone_q    <= zdone_d;
`ifdef STRIDE_MASTER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

`ifdef STRIDE_MASTER_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_axi_stride_read_master.sv
// Directed bench for axi_stride_read_master: a background slave answers AR
// bursts on R; the main initial block launches runs and checks results.
module tb_axi_stride_read_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0, stride = '0, num_reqs = '0;
  logic [7:0]  burst_len = '0, trans_id = '0;
  logic [3:0]  max_outstanding = '0;
  logic        m_ar_valid, m_ar_ready = 1'b0;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len, m_ar_id;
  logic        m_r_valid = 1'b0, m_r_ready, m_r_last = 1'b0;
  logic [7:0]  m_r_data = '0, m_r_id = '0;
  logic        busy, done;
  logic [2:0]  error;
  logic [23:0] beats_rcvd;
`ifdef STRIDE_MASTER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  axi_stride_read_master dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
    .num_reqs(num_reqs), .burst_len(burst_len), .trans_id(trans_id),
    .max_outstanding(max_outstanding),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .busy(busy), .done(done), .error(error),
`ifdef STRIDE_MASTER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .beats_rcvd(beats_rcvd)
  );

  always #5 clk = ~clk;

  // Slave controls, written only by the main initial block.
  logic       rsp_en = 1'b1;
  logic [7:0] rsp_id = 8'd5;
  int         early = -1;
  logic       omit = 1'b0;

  // Slave/monitor state, written only by the responder.
  logic [15:0] ar_log[$];
  int          pend[$];
  int          k = 0, outs = 0, max_outs = 0, done_cnt = 0;
  logic [7:0]  data_ctr = 8'h11;
  logic        ar_s, r_s, last_s;

  // Observe at negedge (values the next posedge will sample), drive at posedge+1.
  always begin
    @(negedge clk);
    ar_s   = m_ar_valid && m_ar_ready;
    r_s    = m_r_valid && m_r_ready;
    last_s = m_r_last;
    if (done) done_cnt++;
    if (ar_s) begin
      ar_log.push_back(m_ar_addr);
      pend.push_back(int'(m_ar_len));
      outs++;
      if (outs > max_outs) max_outs = outs;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
      k = 0; outs = 0; data_ctr = 8'h11;
      m_r_valid = 1'b0; m_r_last = 1'b0;
    end else begin
      if (r_s) begin
        data_ctr = data_ctr + 8'h11;
        if (last_s) begin
          if (pend.size() > 0) void'(pend.pop_front());
          k = 0; outs--;
        end else k++;
      end
      if (rsp_en && pend.size() > 0) begin
        m_r_valid = 1'b1;
        m_r_data  = data_ctr;
        m_r_id    = rsp_id;
        m_r_last  = (k == pend[0]);
        if (early >= 0 && k == early) m_r_last = 1'b1;
        if (omit && k == pend[0]) m_r_last = 1'b0;
        if (omit && k == pend[0] + 1) m_r_last = 1'b1;
      end else begin
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] s, input logic [15:0] n,
                        input logic [7:0] l, input logic [7:0] id, input logic [3:0] lim);
    base_addr = b; stride = s; num_reqs = n; burst_len = l; trans_id = id;
    max_outstanding = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for the done pulse, then confirm it lasts exactly one cycle.
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    tick();
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  int lb, db;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_arvalid", m_ar_valid, 0);
    chk("rst_rready", m_r_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_beats", beats_rcvd, 0);
    rst = 1'b0;
    tick();

    // Basic strided run, always-ready slave
    m_ar_ready = 1'b1;
    lb = ar_log.size(); db = done_cnt;
    launch(16'h0100, 16'd3, 16'd4, 8'd0, 8'd5, 4'd3);
    chk("t1_first_valid", m_ar_valid, 1);
    chk("t1_first_addr", m_ar_addr, 16'h0100);
    chk("t1_busy", busy, 1);
    wait_done("t1");
    chk("t1_nar", ar_log.size() - lb, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_addr%0d", i), ar_log[lb+i], 32'h0100 + 3 * i);
    chk("t1_maxouts_le3", max_outs <= 3, 1);
    chk("t1_beats", beats_rcvd, 4);
    chk("t1_error", error, 0);
    chk("t1_done_pulses", done_cnt - db, 1);

    // num_reqs=0: done next cycle, stays idle
    launch(16'h0100, 16'd3, 16'd0, 8'd0, 8'd5, 4'd3);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    tick();
    chk("z_done_drop", done, 0);

    // AR stall: fields stay stable while valid && !ready
    m_ar_ready = 1'b0;
    lb = ar_log.size();
    launch(16'h0100, 16'd3, 16'd4, 8'd0, 8'd5, 4'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t2_valid%0d", i), m_ar_valid, 1);
      chk($sformatf("t2_addr%0d", i), m_ar_addr, 16'h0100);
      chk($sformatf("t2_len_id%0d", i), {m_ar_len, m_ar_id}, 16'h0005);
    end
    m_ar_ready = 1'b1;
    wait_done("t2");
    chk("t2_nar", ar_log.size() - lb, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_addr_seq%0d", i), ar_log[lb+i], 32'h0100 + 3 * i);

    // Address wrap
    lb = ar_log.size();
    launch(16'hFFFE, 16'd4, 16'd2, 8'd0, 8'd5, 4'd3);
    wait_done("t3");
    chk("t3_addr0", ar_log[lb], 16'hFFFE);
    chk("t3_addr1", ar_log[lb+1], 16'h0002);

    // ID mismatch
    rsp_id = 8'd6;
    launch(16'h0040, 16'd1, 16'd1, 8'd0, 8'd5, 4'd3);
    wait_done("t4");
    chk("t4_error", error, 3'b001);
    chk("t4_beats", beats_rcvd, 1);
    rsp_id = 8'd5;

    // Early last on the second beat of a 4-beat burst
    early = 1;
    launch(16'h0080, 16'd8, 16'd1, 8'd3, 8'd5, 4'd3);
    wait_done("t5");
    chk("t5_error", error, 3'b010);
    chk("t5_beats", beats_rcvd, 2);
    early = -1;

    // Missing last on beat 4; slave closes the burst on a fifth beat
    omit = 1'b1;
    launch(16'h0080, 16'd8, 16'd1, 8'd3, 8'd5, 4'd3);
    wait_done("t6");
    chk("t6_error", error, 3'b100);
    chk("t6_beats", beats_rcvd, 5);
    omit = 1'b0;

    // Outstanding limit, then reset with two bursts in flight
    rsp_en = 1'b0;
    lb = ar_log.size();
    launch(16'h0200, 16'h0010, 16'd4, 8'd0, 8'd5, 4'd2);
    for (int i = 0; i < 6; i++) tick();
    chk("t7_nar_limited", ar_log.size() - lb, 2);
    chk("t7_valid_blocked", m_ar_valid, 0);
    chk("t7_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_valid", m_ar_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_error", error, 0);
    chk("t7_rst_beats", beats_rcvd, 0);
    tick();
    rst = 1'b0;
    rsp_en = 1'b1;
    tick();

    // Clean run after reset (slave data 0x11, 0x22)
    lb = ar_log.size();
    launch(16'h0100, 16'd3, 16'd2, 8'd0, 8'd5, 4'd3);
    wait_done("t8");
    chk("t8_nar", ar_log.size() - lb, 2);
    chk("t8_addr1", ar_log[lb+1], 16'h0103);
    chk("t8_beats", beats_rcvd, 2);
    chk("t8_error", error, 0);
`ifdef STRIDE_MASTER_CHECKSUM_EN
    chk("t8_checksum", checksum, 8'h33);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
